vga_pixel_filter_pipe: RTL and testbench

Parametrised, pipelined pixel post-processing stage between the image source (ROM reader or future frame buffer) and the VGA RGB/sync pins. It replaces the combinational grayscale-plus-2:1-mux path with four selectable filter modes, a fixed two-cycle registered latency, and matching delay of DE/h_sync/v_sync. Mode changes are frame-synchronous: they take effect only at a frame boundary, never mid-frame.

---
 rtl/vga_filter_pkg.sv | 22 ++
 rtl/luma_calc.sv | 49 ++++
 rtl/vga_pixel_filter_pipe.sv | 180 ++++++++++++++++++
 tb/tb_vga_pixel_filter_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_filter_pkg
// Purpose  : Filter mode encoding and luma coefficients for the VGA pixel pipe.
// Revision : 1.0
// ============================================================================
package vga_filter_pkg;

    typedef enum logic [1:0] {
        PASS   = 2'd0,
        GRAY   = 2'd1,
        INVERT = 2'd2,
        THRESH = 2'd3
    } filt_mode_e;

    localparam int unsigned LUMA_R     = 77;
    localparam int unsigned LUMA_G     = 150;
    localparam int unsigned LUMA_B     = 29;
    localparam int unsigned LUMA_SHIFT = 8;

endpackage : vga_filter_pkg
`default_nettype wire

// File: rtl/luma_calc.sv
`default_nettype none
// ============================================================================
// Module   : luma_calc
// Purpose  : Two-stage luma pipeline: weighted products, then sum and shift.
// Revision : 1.0
// ============================================================================
module luma_calc
    import vga_filter_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] i_r,
    input  logic [CW-1:0] i_g,
    input  logic [CW-1:0] i_b,
    output logic [CW-1:0] o_luma
);

    // Coefficients sum to 256, so the sum never exceeds CW+8 bits.
    localparam int SW = CW + LUMA_SHIFT;

    localparam logic [SW-1:0] c_coef_r = SW'(LUMA_R);
    localparam logic [SW-1:0] c_coef_g = SW'(LUMA_G);
    localparam logic [SW-1:0] c_coef_b = SW'(LUMA_B);

    logic [SW-1:0] r_prod_r;
    logic [SW-1:0] r_prod_g;
    logic [SW-1:0] r_prod_b;
    logic [SW-1:0] r_sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prod_r <= '0;
            r_prod_g <= '0;
            r_prod_b <= '0;
            r_sum    <= '0;
        end else begin
            r_prod_r <= SW'(i_r) * c_coef_r;
            r_prod_g <= SW'(i_g) * c_coef_g;
            r_prod_b <= SW'(i_b) * c_coef_b;
            r_sum    <= r_prod_r + r_prod_g + r_prod_b;
        end
    end

    assign o_luma = r_sum[SW-1:LUMA_SHIFT];

endmodule : luma_calc
`default_nettype wire

// File: rtl/vga_pixel_filter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_filter_pipe
// Purpose  : Two-cycle pixel filter (pass/gray/invert/threshold) with
//            frame-synchronous mode switching and aligned DE/sync delay.
// Revision : 1.0
// ============================================================================
module vga_pixel_filter_pipe
    import vga_filter_pkg::*;
#(
    parameter int CW           = 4,
    parameter int FCW          = 8,
    parameter bit SYNC_ACT_LOW = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     mode_sel,
    input  logic [CW-1:0]  thresh,
    input  logic           i_de,
    input  logic           i_h_sync,
    input  logic           i_v_sync,
    input  logic [CW-1:0]  i_r,
    input  logic [CW-1:0]  i_g,
    input  logic [CW-1:0]  i_b,
    output logic           o_de,
    output logic           o_h_sync,
    output logic           o_v_sync,
    output logic [CW-1:0]  o_r,
    output logic [CW-1:0]  o_g,
    output logic [CW-1:0]  o_b,
    output logic [1:0]     o_mode,
    output logic [FCW-1:0] o_frame_cnt
);

    localparam logic c_sync_idle = SYNC_ACT_LOW;
    localparam logic c_sync_act  = ~SYNC_ACT_LOW;

    logic           r_vs_prev;
    filt_mode_e     r_mode;
    logic [CW-1:0]  r_thr;
    logic [FCW-1:0] r_frame_cnt;

    logic           w_frame_start;
    filt_mode_e     w_mode_next;
    logic [CW-1:0]  w_thr_next;

    logic           r_s1_de, r_s1_hs, r_s1_vs;
    filt_mode_e     r_s1_mode;
    logic [CW-1:0]  r_s1_thr, r_s1_r, r_s1_g, r_s1_b;

    logic           r_s2_de, r_s2_hs, r_s2_vs;
    filt_mode_e     r_s2_mode;
    logic [CW-1:0]  r_s2_thr, r_s2_r, r_s2_g, r_s2_b;

    logic [CW-1:0]  w_luma;
    logic           w_hit;
    logic [CW-1:0]  w_r, w_g, w_b;

    assign w_frame_start = (i_v_sync == c_sync_act) && (r_vs_prev == c_sync_idle);

    // A pixel entering stage 1 on the event edge already sees the new mode.
    assign w_mode_next = w_frame_start ? filt_mode_e'(mode_sel) : r_mode;
    assign w_thr_next  = w_frame_start ? thresh : r_thr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vs_prev   <= c_sync_idle;
            r_mode      <= PASS;
            r_thr       <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_vs_prev <= i_v_sync;
            r_mode    <= w_mode_next;
            r_thr     <= w_thr_next;
            if (w_frame_start) begin
                r_frame_cnt <= r_frame_cnt + FCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_de   <= 1'b0;
            r_s1_hs   <= c_sync_idle;
            r_s1_vs   <= c_sync_idle;
            r_s1_mode <= PASS;
            r_s1_thr  <= '0;
            r_s1_r    <= '0;
            r_s1_g    <= '0;
            r_s1_b    <= '0;
            r_s2_de   <= 1'b0;
            r_s2_hs   <= c_sync_idle;
            r_s2_vs   <= c_sync_idle;
            r_s2_mode <= PASS;
            r_s2_thr  <= '0;
            r_s2_r    <= '0;
            r_s2_g    <= '0;
            r_s2_b    <= '0;
        end else begin
            r_s1_de   <= i_de;
            r_s1_hs   <= i_h_sync;
            r_s1_vs   <= i_v_sync;
            r_s1_mode <= w_mode_next;
            r_s1_thr  <= w_thr_next;
            r_s1_r    <= i_r;
            r_s1_g    <= i_g;
            r_s1_b    <= i_b;
            r_s2_de   <= r_s1_de;
            r_s2_hs   <= r_s1_hs;
            r_s2_vs   <= r_s1_vs;
            r_s2_mode <= r_s1_mode;
            r_s2_thr  <= r_s1_thr;
            r_s2_r    <= r_s1_r;
            r_s2_g    <= r_s1_g;
            r_s2_b    <= r_s1_b;
        end
    end

    luma_calc #(
        .CW (CW)
    ) u_luma (
        .clk    (clk),
        .reset  (reset),
        .i_r    (i_r),
        .i_g    (i_g),
        .i_b    (i_b),
        .o_luma (w_luma)
    );

    assign w_hit = (w_luma >= r_s2_thr);

    always_comb begin
        w_r = r_s2_r;
        w_g = r_s2_g;
        w_b = r_s2_b;
        case (r_s2_mode)
            PASS: begin
                w_r = r_s2_r;
                w_g = r_s2_g;
                w_b = r_s2_b;
            end
            GRAY: begin
                w_r = w_luma;
                w_g = w_luma;
                w_b = w_luma;
            end
            INVERT: begin
                w_r = ~r_s2_r;
                w_g = ~r_s2_g;
                w_b = ~r_s2_b;
            end
            THRESH: begin
                w_r = {CW{w_hit}};
                w_g = {CW{w_hit}};
                w_b = {CW{w_hit}};
            end
            default: begin
                w_r = r_s2_r;
                w_g = r_s2_g;
                w_b = r_s2_b;
            end
        endcase
        if (!r_s2_de) begin
            w_r = '0;
            w_g = '0;
            w_b = '0;
        end
    end

    assign o_de        = r_s2_de;
    assign o_h_sync    = r_s2_hs;
    assign o_v_sync    = r_s2_vs;
    assign o_r         = w_r;
    assign o_g         = w_g;
    assign o_b         = w_b;
    assign o_mode      = r_mode;
    assign o_frame_cnt = r_frame_cnt;

endmodule : vga_pixel_filter_pipe
`default_nettype wire

// File: tb/tb_vga_pixel_filter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pixel_filter_pipe
// Purpose  : Directed table-driven bench for vga_pixel_filter_pipe.
// Revision : 1.0
// ============================================================================
module tb_vga_pixel_filter_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode_sel;
    logic [3:0] thresh;
    logic       i_de, i_h_sync, i_v_sync;
    logic [3:0] i_r, i_g, i_b;
    logic       o_de, o_h_sync, o_v_sync;
    logic [3:0] o_r, o_g, o_b;
    logic [1:0] o_mode;
    logic [7:0] o_frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_cnt = '0;

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  thr;
        logic        de;
        logic [3:0]  r, g, b;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t vecs[15];

    vga_pixel_filter_pipe #(
        .CW           (4),
        .FCW          (8),
        .SYNC_ACT_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode_sel    (mode_sel),
        .thresh      (thresh),
        .i_de        (i_de),
        .i_h_sync    (i_h_sync),
        .i_v_sync    (i_v_sync),
        .i_r         (i_r),
        .i_g         (i_g),
        .i_b         (i_b),
        .o_de        (o_de),
        .o_h_sync    (o_h_sync),
        .o_v_sync    (o_v_sync),
        .o_r         (o_r),
        .o_g         (o_g),
        .o_b         (o_b),
        .o_mode      (o_mode),
        .o_frame_cnt (o_frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic de, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        i_de = de;
        i_r  = r;
        i_g  = g;
        i_b  = b;
    endtask

    // One frame-start event (v_sync falling edge) carrying the requested mode.
    task automatic set_mode(input logic [1:0] m, input logic [3:0] t);
        mode_sel = m;
        thresh   = t;
        i_v_sync = 1'b0;
        step();
        exp_cnt++;
        chk("set_mode_o_mode", 32'(o_mode), 32'(m));
        chk("set_mode_frame_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
        i_v_sync = 1'b1;
        step();
    endtask

    initial begin
        logic [1:0] cur_mode;
        logic [3:0] cur_thr;
        logic [7:0] cnt_start;

        vecs[0]  = '{2'd0, 4'd0, 1'b1, 4'hA, 4'h5, 4'h3, 12'hA53};
        vecs[1]  = '{2'd0, 4'd0, 1'b0, 4'hA, 4'h5, 4'h3, 12'h000};
        vecs[2]  = '{2'd1, 4'd0, 1'b1, 4'hF, 4'h0, 4'h0, 12'h444};
        vecs[3]  = '{2'd1, 4'd0, 1'b1, 4'h0, 4'hF, 4'h0, 12'h888};
        vecs[4]  = '{2'd1, 4'd0, 1'b1, 4'h0, 4'h0, 4'hF, 12'h111};
        vecs[5]  = '{2'd1, 4'd0, 1'b1, 4'hF, 4'hF, 4'hF, 12'hFFF};
        vecs[6]  = '{2'd1, 4'd0, 1'b1, 4'h0, 4'h0, 4'h0, 12'h000};
        vecs[7]  = '{2'd1, 4'd0, 1'b1, 4'hA, 4'h5, 4'h3, 12'h666};
        vecs[8]  = '{2'd2, 4'd0, 1'b1, 4'hA, 4'h5, 4'h3, 12'h5AC};
        vecs[9]  = '{2'd2, 4'd0, 1'b0, 4'hF, 4'hF, 4'hF, 12'h000};
        vecs[10] = '{2'd2, 4'd0, 1'b1, 4'h0, 4'h0, 4'h0, 12'hFFF};
        vecs[11] = '{2'd3, 4'd8, 1'b1, 4'hF, 4'hF, 4'hF, 12'hFFF};
        vecs[12] = '{2'd3, 4'd8, 1'b1, 4'hF, 4'h0, 4'h0, 12'h000};
        vecs[13] = '{2'd3, 4'd8, 1'b1, 4'h0, 4'hF, 4'h0, 12'hFFF};
        vecs[14] = '{2'd3, 4'd8, 1'b1, 4'h3, 4'hC, 4'h0, 12'h000};

        reset    = 1'b0;
        mode_sel = 2'd0;
        thresh   = 4'd0;
        i_h_sync = 1'b1;
        i_v_sync = 1'b1;
        set_pix(1'b0, 4'h0, 4'h0, 4'h0);
        step();
        step();
        chk("rst_de", 32'(o_de), 32'd0);
        chk("rst_syncs", 32'({o_h_sync, o_v_sync}), 32'h3);
        chk("rst_rgb", 32'({o_r, o_g, o_b}), 32'h0);
        chk("rst_mode_cnt", 32'({o_mode, o_frame_cnt}), 32'h0);
        reset = 1'b1;
        step();

        // Table: switch mode via a frame event only when the record asks for it.
        cur_mode = 2'd0;
        cur_thr  = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].mode != cur_mode || vecs[i].thr != cur_thr) begin
                set_mode(vecs[i].mode, vecs[i].thr);
                cur_mode = vecs[i].mode;
                cur_thr  = vecs[i].thr;
            end
            set_pix(vecs[i].de, vecs[i].r, vecs[i].g, vecs[i].b);
            step();
            step();
            chk($sformatf("vec%0d_rgb", i), 32'({o_r, o_g, o_b}), 32'(vecs[i].exp_rgb));
            chk($sformatf("vec%0d_de", i), 32'(o_de), 32'(vecs[i].de));
        end

        // Mid-frame asynchronous reset while THRESH output is active.
        set_pix(1'b1, 4'hF, 4'hF, 4'hF);
        i_h_sync = 1'b0;
        step();
        step();
        chk("pre_rst_rgb", 32'({o_r, o_g, o_b}), 32'hFFF);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_de", 32'(o_de), 32'd0);
        chk("async_rst_syncs", 32'({o_h_sync, o_v_sync}), 32'h3);
        chk("async_rst_rgb", 32'({o_r, o_g, o_b}), 32'h0);
        chk("async_rst_mode_cnt", 32'({o_mode, o_frame_cnt}), 32'h0);
        exp_cnt = '0;
        set_pix(1'b0, 4'h0, 4'h0, 4'h0);
        i_h_sync = 1'b1;
        mode_sel = 2'd3;
        step();
        reset = 1'b1;
        step();
        step();
        chk("post_rst_mode", 32'(o_mode), 32'd0);
        chk("post_rst_blank", 32'({o_de, o_r, o_g, o_b}), 32'h0);

        // Latency: one-cycle DE/h_sync pulse with a pixel in PASS mode.
        mode_sel = 2'd0;
        set_pix(1'b1, 4'hA, 4'h5, 4'h3);
        i_h_sync = 1'b0;
        step();
        chk("lat1_de_hs", 32'({o_de, o_h_sync}), 32'h1);
        chk("lat1_rgb", 32'({o_r, o_g, o_b}), 32'h0);
        set_pix(1'b0, 4'h0, 4'h0, 4'h0);
        i_h_sync = 1'b1;
        step();
        chk("lat2_de_hs", 32'({o_de, o_h_sync}), 32'h2);
        chk("lat2_rgb", 32'({o_r, o_g, o_b}), 32'hA53);
        step();
        chk("lat3_de_hs", 32'({o_de, o_h_sync}), 32'h1);
        chk("lat3_rgb", 32'({o_r, o_g, o_b}), 32'h0);

        // Frame sync: INVERT requested mid-frame takes effect only at v_sync fall.
        set_pix(1'b1, 4'hA, 4'h5, 4'h3);
        mode_sel = 2'd2;
        step();
        step();
        step();
        chk("fs_mode_hold", 32'(o_mode), 32'd0);
        chk("fs_rgb_before", 32'({o_r, o_g, o_b}), 32'hA53);
        i_v_sync = 1'b0;
        step();
        exp_cnt++;
        chk("fs_mode_new", 32'(o_mode), 32'd2);
        chk("fs_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
        chk("fs_vs_delay1", 32'(o_v_sync), 32'd1);
        chk("fs_rgb_old_pixel", 32'({o_r, o_g, o_b}), 32'hA53);
        mode_sel = 2'd1;
        step();
        chk("fs_rgb_new_pixel", 32'({o_r, o_g, o_b}), 32'h5AC);
        chk("fs_vs_delay2", 32'(o_v_sync), 32'd0);
        i_v_sync = 1'b1;
        step();
        chk("fs_low_toggle_ignored", 32'(o_mode), 32'd2);
        chk("fs_cnt_hold", 32'(o_frame_cnt), 32'(exp_cnt));
        step();
        chk("fs_vs_rise", 32'(o_v_sync), 32'd1);

        // Mode value present in the event cycle is the one captured.
        mode_sel = 2'd0;
        step();
        mode_sel = 2'd1;
        i_v_sync = 1'b0;
        step();
        exp_cnt++;
        mode_sel = 2'd2;
        i_v_sync = 1'b1;
        step();
        chk("same_cycle_capture", 32'(o_mode), 32'd1);

        // 256 frames return the 8-bit counter to its start value.
        cnt_start = exp_cnt;
        for (int f = 0; f < 256; f++) begin
            set_mode(2'd2, 4'd0);
        end
        chk("frame_wrap", 32'(o_frame_cnt), 32'(cnt_start));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_vga_pixel_filter_pipe
`default_nettype wire
